// File: rtl/misc_opcode_encoder_pkg.sv
// Shared opcode types and the misc-opcode encode/decode helpers.
package OpPkg;

  typedef enum logic [6:0] {
    OP08 = 7'h08,
    OP09 = 7'h09,
    OP60 = 7'h60,
    OP61 = 7'h61,
    OP62 = 7'h62,
    OP66 = 7'h66,
    OP67 = 7'h67
  } Opcode_e;

  typedef enum logic [2:0] {
    MISC0 = 3'd0,
    MISC1 = 3'd1,
    MISC2 = 3'd2,
    MISC3 = 3'd3,
    MISC4 = 3'd4,
    MISC5 = 3'd5,
    MISC6 = 3'd6
  } MiscOpcode_e;

  typedef struct packed {
    logic        valid;
    MiscOpcode_e misc;
  } misc_enc_t;

  function automatic Opcode_e decode_misc(MiscOpcode_e m);
    Opcode_e op;
    op = OP61;
    unique case (m)
      MISC0:   op = OP61;
      MISC1:   op = OP60;
      MISC2:   op = OP09;
      MISC3:   op = OP08;
      MISC4:   op = OP66;
      MISC5:   op = OP67;
      MISC6:   op = OP62;
      default: op = OP61;
    endcase
    return op;
  endfunction

  // Inverse of decode_misc; anything outside the seven mapped opcodes is invalid.
  function automatic misc_enc_t encode_misc(Opcode_e op);
    misc_enc_t r;
    r.valid = 1'b1;
    r.misc  = MISC0;
    unique case (op)
      OP61:    r.misc = MISC0;
      OP60:    r.misc = MISC1;
      OP09:    r.misc = MISC2;
      OP08:    r.misc = MISC3;
      OP66:    r.misc = MISC4;
      OP67:    r.misc = MISC5;
      OP62:    r.misc = MISC6;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/misc_stash_fifo2.sv
// Two-entry FIFO with registered full/empty; head reads as zero when empty.
module misc_stash_fifo2 #(
  parameter int unsigned DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/misc_opcode_encoder.sv
// Encodes opcodes into misc opcodes through a 2-deep stash, counting unmapped inputs.
module misc_opcode_encoder
  import OpPkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  Opcode_e          in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output MiscOpcode_e      out_stash,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  misc_enc_t  enc;
  logic       accept;
  logic       push;
  logic       bad;
  logic       full;
  logic       empty;
  logic [2:0] head;

  assign enc      = encode_misc(in_opcode);
  assign in_ready = ~full & ~rst;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc.valid;
  assign bad      = accept & ~enc.valid;

  misc_stash_fifo2 #(.DW(3)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (enc.misc),
    .pop       (out_ready),
    .full      (full),
    .empty     (empty),
    .head_data (head)
  );

  assign out_valid = ~empty;
  assign out_stash = MiscOpcode_e'(head);

  // Clear has priority over a same-cycle increment; count saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= bad;
      if (err_clr)
        err_count <= '0;
      else if (bad && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_misc_opcode_encoder.sv
// Scoreboard bench: queue-based reference model, directed scenarios then random traffic.
module tb_misc_opcode_encoder;
  import OpPkg::*;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  Opcode_e       in_opcode;
  logic          out_valid;
  logic          out_ready;
  MiscOpcode_e   out_stash;
  logic          err_pulse;
  logic [CW-1:0] err_count;
  logic          err_clr;

  always #5 clk = ~clk;

  misc_opcode_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_stash (out_stash),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Mapped opcodes listed in misc-code order: table index == expected misc code.
  logic [6:0] tbl [7] = '{7'h61, 7'h60, 7'h09, 7'h08, 7'h66, 7'h67, 7'h62};

  int exp_q [$];
  int exp_cnt   = 0;
  bit exp_pulse = 0;
  int occ_pre   = 0;
  int e_code;
  bit acc;

  function automatic int ref_encode(input logic [6:0] op);
    for (int i = 0; i < 7; i++)
      if (tbl[i] == op) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state against the model just before the next rising edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_err_pulse", int'(err_pulse), 0);
      chk("rst_err_count", int'(err_count), 0);
      chk("rst_out_stash", int'(out_stash), 0);
    end else begin
      occ_pre = exp_q.size();
      chk("in_ready", int'(in_ready), int'(occ_pre < 2));
      chk("out_valid", int'(out_valid), int'(occ_pre != 0));
      chk("err_pulse", int'(err_pulse), int'(exp_pulse));
      chk("err_count", int'(err_count), exp_cnt);
      if (out_valid && occ_pre != 0) begin
        chk("out_stash", int'(out_stash), exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Stimulus side of the scoreboard: push expected results for this edge's accept.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      exp_cnt   = 0;
      exp_pulse = 0;
    end else begin
      acc       = in_valid && (occ_pre < 2);
      e_code    = ref_encode(in_opcode);
      exp_pulse = acc && (e_code < 0);
      if (err_clr)
        exp_cnt = 0;
      else if (acc && e_code < 0 && exp_cnt < (1 << CW) - 1)
        exp_cnt++;
      if (acc && e_code >= 0) exp_q.push_back(e_code);
    end
  end

  task automatic drive(input bit v, input logic [6:0] op, input bit rdy, input bit clr);
    @(negedge clk);
    in_valid  = v;
    in_opcode = Opcode_e'(op);
    out_ready = rdy;
    err_clr   = clr;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 7'h61, rdy, 1'b0);
  endtask

  task automatic pulse_rst(input int n);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [6:0] bad_ops [6] = '{7'h00, 7'h7f, 7'h10, 7'h63, 7'h65, 7'h01};
  logic [6:0] rop;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = OP61;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Seven mapped opcodes back-to-back, downstream always ready.
    for (int i = 0; i < 7; i++) drive(1'b1, tbl[i], 1'b1, 1'b0);
    idle(3, 1'b1);

    // Backpressure: fill both entries, third offer refused, then drain in order.
    drive(1'b1, 7'h66, 1'b0, 1'b0);
    drive(1'b1, 7'h08, 1'b0, 1'b0);
    drive(1'b1, 7'h61, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Unmapped opcode followed by a mapped one.
    drive(1'b1, 7'h00, 1'b1, 1'b0);
    drive(1'b1, 7'h09, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Saturation (count width 2), then clear beating a same-cycle increment.
    for (int i = 0; i < 5; i++) drive(1'b1, bad_ops[i], 1'b1, 1'b0);
    drive(1'b1, bad_ops[5], 1'b1, 1'b1);
    idle(3, 1'b1);

    // Push and pop together at occupancy one.
    drive(1'b1, 7'h61, 1'b0, 1'b0);
    drive(1'b1, 7'h67, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Reset with two entries buffered; only new traffic afterwards.
    drive(1'b1, 7'h60, 1'b0, 1'b0);
    drive(1'b1, 7'h62, 1'b0, 1'b0);
    pulse_rst(2);
    drive(1'b1, 7'h09, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0) rop = tbl[$urandom_range(0, 6)];
      else                           rop = 7'($urandom);
      drive(1'($urandom_range(0, 1)), rop, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 149) == 0) pulse_rst(1);
    end
    idle(5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
